// File: rtl/seg_serial_pkg.sv
// Shared types and sizing helpers for the segment serial loader.
// Optional chain-clear phase is enabled by defining SEG_SERIAL_LOADER_CLEAR_EN.
package seg_serial_pkg;

   localparam int NUM_BYTES_MIN = 1;
   localparam int NUM_BYTES_MAX = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SHIFT_LO,
      ST_SHIFT_HI,
      ST_DONE
`ifdef SEG_SERIAL_LOADER_CLEAR_EN
      , ST_CLEAR
`endif
   } seg_ld_state_t;

   // Divider width; a divide-by-one still needs a 1-bit counter to exist.
   function automatic int cnt_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sr_tick_gen.sv
// Half-period divider: o_tick pulses on the last of every DIV enabled cycles.
// Down-counter with terminal-count compare, reloaded while cleared.
module sr_tick_gen
   import seg_serial_pkg::*;
#(
   parameter int DIV = 4
) (
   input  logic CP,
   input  logic MR_n,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_tick
);

   localparam int W = cnt_width(DIV);
   localparam logic [W-1:0] RELOAD = W'(DIV - 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge CP or negedge MR_n) begin
      if (!MR_n) begin
         r_cnt <= RELOAD;
      end else if (i_clear) begin
         r_cnt <= RELOAD;
      end else if (i_enable) begin
         r_cnt <= (r_cnt == '0) ? RELOAD : r_cnt - 1'b1;
      end
   end

   assign o_tick = i_enable && (r_cnt == '0);

endmodule

// File: rtl/seg_serial_loader.sv
// Serial feeder for a chain of 8-bit SIPO shift registers; MSB-first, divided shift clock.
// Define SEG_SERIAL_LOADER_CLEAR_EN to pulse the chain clear before every frame.
//
// state       | meaning
// ST_IDLE     | ready, waiting for start
// ST_CLEAR    | SR_MR_n held low for 2*DIV cycles (optional)
// ST_SHIFT_LO | SR_CP low, SR_DS set up with the current MSB
// ST_SHIFT_HI | SR_CP high, SR_DS held; shift on the last cycle
// ST_DONE     | one-cycle done pulse
module seg_serial_loader
   import seg_serial_pkg::*;
#(
   parameter int NUM_BYTES = 4,
   parameter int DIV       = 4
) (
   input  logic                   CP,
   input  logic                   MR_n,
   input  logic                   start,
   input  logic [8*NUM_BYTES-1:0] data,
   output logic                   ready,
   output logic                   busy,
   output logic                   done,
   output logic                   SR_DS,
   output logic                   SR_CP,
   output logic                   SR_MR_n
);

   localparam int FW = 8 * NUM_BYTES;
   localparam int BW = $clog2(FW + 1);
   localparam logic [BW-1:0] FW_CNT = BW'(FW);

   if (NUM_BYTES < NUM_BYTES_MIN || NUM_BYTES > NUM_BYTES_MAX) begin : g_bad_bytes
      $fatal(1, "seg_serial_loader: NUM_BYTES must be 1..8");
   end
   if (DIV < 1) begin : g_bad_div
      $fatal(1, "seg_serial_loader: DIV must be >= 1");
   end

   seg_ld_state_t r_state, w_state_nx;
   logic [FW-1:0] r_sreg, w_sreg_nx;
   logic [BW-1:0] r_bcnt, w_bcnt_nx;
   logic          r_ready, r_busy, r_done, r_sr_ds, r_sr_cp, r_sr_mr_n;
   logic          w_ready_nx, w_busy_nx, w_done_nx, w_sr_ds_nx, w_sr_cp_nx, w_sr_mr_n_nx;
   logic          w_enable, w_tick;
`ifdef SEG_SERIAL_LOADER_CLEAR_EN
   logic          r_clr_phase, w_clr_phase_nx;
`endif

`ifdef SEG_SERIAL_LOADER_CLEAR_EN
   assign w_enable = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI) ||
                     (r_state == ST_CLEAR);
`else
   assign w_enable = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI);
`endif

   sr_tick_gen #(.DIV(DIV)) u_tick (
      .CP       (CP),
      .MR_n     (MR_n),
      .i_clear  (!w_enable),
      .i_enable (w_enable),
      .o_tick   (w_tick)
   );

   always_comb begin
      w_state_nx = r_state;
      w_sreg_nx  = r_sreg;
      w_bcnt_nx  = r_bcnt;
`ifdef SEG_SERIAL_LOADER_CLEAR_EN
      w_clr_phase_nx = r_clr_phase;
`endif
      case (r_state)
         ST_IDLE: begin
            if (start && r_ready) begin
               w_sreg_nx = data;
               w_bcnt_nx = FW_CNT;
`ifdef SEG_SERIAL_LOADER_CLEAR_EN
               w_state_nx     = ST_CLEAR;
               w_clr_phase_nx = 1'b0;
`else
               w_state_nx = ST_SHIFT_LO;
`endif
            end
         end
`ifdef SEG_SERIAL_LOADER_CLEAR_EN
         // Two divider half-periods make up the 2*DIV clear pulse.
         ST_CLEAR: begin
            if (w_tick) begin
               w_clr_phase_nx = !r_clr_phase;
               if (r_clr_phase) w_state_nx = ST_SHIFT_LO;
            end
         end
`endif
         ST_SHIFT_LO: begin
            if (w_tick) w_state_nx = ST_SHIFT_HI;
         end
         ST_SHIFT_HI: begin
            if (w_tick) begin
               w_sreg_nx  = {r_sreg[FW-2:0], 1'b0};
               w_bcnt_nx  = r_bcnt - 1'b1;
               w_state_nx = (r_bcnt == BW'(1)) ? ST_DONE : ST_SHIFT_LO;
            end
         end
         ST_DONE: w_state_nx = ST_IDLE;
         default: w_state_nx = ST_IDLE;
      endcase

      // Outputs are registered from the next state so they line up with it.
      w_ready_nx   = (w_state_nx == ST_IDLE);
      w_busy_nx    = !w_ready_nx;
      w_done_nx    = (w_state_nx == ST_DONE);
      w_sr_cp_nx   = (w_state_nx == ST_SHIFT_HI);
      w_sr_ds_nx   = ((w_state_nx == ST_SHIFT_LO) || (w_state_nx == ST_SHIFT_HI)) ?
                     w_sreg_nx[FW-1] : 1'b0;
`ifdef SEG_SERIAL_LOADER_CLEAR_EN
      w_sr_mr_n_nx = (w_state_nx != ST_CLEAR);
`else
      w_sr_mr_n_nx = 1'b1;
`endif
   end

   always_ff @(posedge CP or negedge MR_n) begin
      if (!MR_n) begin
         r_state   <= ST_IDLE;
         r_sreg    <= '0;
         r_bcnt    <= '0;
         r_ready   <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sr_ds   <= 1'b0;
         r_sr_cp   <= 1'b0;
         r_sr_mr_n <= 1'b0;
      end else begin
         r_state   <= w_state_nx;
         r_sreg    <= w_sreg_nx;
         r_bcnt    <= w_bcnt_nx;
         r_ready   <= w_ready_nx;
         r_busy    <= w_busy_nx;
         r_done    <= w_done_nx;
         r_sr_ds   <= w_sr_ds_nx;
         r_sr_cp   <= w_sr_cp_nx;
         r_sr_mr_n <= w_sr_mr_n_nx;
      end
   end

`ifdef SEG_SERIAL_LOADER_CLEAR_EN
   always_ff @(posedge CP or negedge MR_n) begin
      if (!MR_n) r_clr_phase <= 1'b0;
      else       r_clr_phase <= w_clr_phase_nx;
   end
`endif

   assign ready   = r_ready;
   assign busy    = r_busy;
   assign done    = r_done;
   assign SR_DS   = r_sr_ds;
   assign SR_CP   = r_sr_cp;
   assign SR_MR_n = r_sr_mr_n;

endmodule

// File: tb/tb_seg_serial_loader.sv
// Directed bench: three loader instances feeding behavioural 74LS164 chain models.
module tb_seg_serial_loader;

`ifdef SEG_SERIAL_LOADER_CLEAR_EN
   localparam int CLR = 1;
`else
   localparam int CLR = 0;
`endif
   // Expected done cycles: 1 + 2*DIV*8*NUM_BYTES (+2*DIV with the clear phase).
   localparam int LA = 17 + CLR * 2;
   localparam int LB = 257 + CLR * 8;
   localparam int LC = 33 + CLR * 4;

   logic CP = 1'b0;
   logic MR_n = 1'b0;
   always #5 CP = ~CP;

   logic        a_start = 0, b_start = 0, c_start = 0;
   logic [7:0]  a_data = '0, c_data = '0;
   logic [31:0] b_data = '0;
   logic a_ready, a_busy, a_done, a_ds, a_cp, a_mr;
   logic b_ready, b_busy, b_done, b_ds, b_cp, b_mr;
   logic c_ready, c_busy, c_done, c_ds, c_cp, c_mr;

   seg_serial_loader #(.NUM_BYTES(1), .DIV(1)) u_a (
      .CP(CP), .MR_n(MR_n), .start(a_start), .data(a_data), .ready(a_ready),
      .busy(a_busy), .done(a_done), .SR_DS(a_ds), .SR_CP(a_cp), .SR_MR_n(a_mr));
   seg_serial_loader #(.NUM_BYTES(4), .DIV(4)) u_b (
      .CP(CP), .MR_n(MR_n), .start(b_start), .data(b_data), .ready(b_ready),
      .busy(b_busy), .done(b_done), .SR_DS(b_ds), .SR_CP(b_cp), .SR_MR_n(b_mr));
   seg_serial_loader #(.NUM_BYTES(1), .DIV(2)) u_c (
      .CP(CP), .MR_n(MR_n), .start(c_start), .data(c_data), .ready(c_ready),
      .busy(c_busy), .done(c_done), .SR_DS(c_ds), .SR_CP(c_cp), .SR_MR_n(c_mr));

   // Chain models: bit 0 is Q0 of the first register, top bit is Q7 of the last.
   logic [7:0]  chain_a = '0, chain_c = '0;
   logic [31:0] chain_b = '0;
   int ecnt_a = 0, ecnt_b = 0, ecnt_c = 0;
   always @(posedge a_cp or negedge a_mr)
      if (!a_mr) chain_a <= '0;
      else begin chain_a <= {chain_a[6:0], a_ds}; ecnt_a <= ecnt_a + 1; end
   always @(posedge b_cp or negedge b_mr)
      if (!b_mr) chain_b <= '0;
      else begin chain_b <= {chain_b[30:0], b_ds}; ecnt_b <= ecnt_b + 1; end
   always @(posedge c_cp or negedge c_mr)
      if (!c_mr) chain_c <= '0;
      else begin chain_c <= {chain_c[6:0], c_ds}; ecnt_c <= ecnt_c + 1; end

   int sel = 0;
   logic m_ready, m_busy, m_done, m_cp, m_mr;
   logic [31:0] m_chain;
   int m_ecnt;
   always_comb begin
      m_ready = a_ready; m_busy = a_busy; m_done = a_done; m_cp = a_cp; m_mr = a_mr;
      m_chain = {24'h0, chain_a}; m_ecnt = ecnt_a;
      if (sel == 1) begin
         m_ready = b_ready; m_busy = b_busy; m_done = b_done; m_cp = b_cp; m_mr = b_mr;
         m_chain = chain_b; m_ecnt = ecnt_b;
      end else if (sel == 2) begin
         m_ready = c_ready; m_busy = c_busy; m_done = c_done; m_cp = c_cp; m_mr = c_mr;
         m_chain = {24'h0, chain_c}; m_ecnt = ecnt_c;
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_in(input int s, input logic st, input logic [31:0] d);
      case (s)
         0: begin a_start = st; a_data = d[7:0]; end
         1: begin b_start = st; b_data = d; end
         default: begin c_start = st; c_data = d[7:0]; end
      endcase
   endtask

   task automatic wait_ready(input int s);
      int n;
      sel = s;
      n = 0;
      @(negedge CP);
      while (!m_ready && n < 50) begin @(negedge CP); n++; end
   endtask

   task automatic run_frame(input int s, input logic [31:0] d, input int poke, input int pre_cyc,
                            output int done_cyc, output int edges, output int viol,
                            output int mr_low, output int hmin, output int hmax,
                            output int lmin, output int lmax, output logic [31:0] pre_chain);
      int base, cyc, run;
      logic lvl;
      bit first;
      wait_ready(s);
      base = m_ecnt;
      set_in(s, 1'b1, d);
      cyc = 0; done_cyc = -1; viol = 0; mr_low = 0; pre_chain = '0;
      hmin = 9999; hmax = 0; lmin = 9999; lmax = 0;
      run = 0; lvl = 1'b0; first = 1;
      while (done_cyc < 0 && cyc < 3000) begin
         @(negedge CP);
         cyc++;
         if (poke > 0 && cyc >= poke && cyc < poke + 3) set_in(s, 1'b1, 32'hFFFF_FFFF);
         else set_in(s, 1'b0, d);
         if (!(m_busy && !m_ready)) viol++;
         if (!m_mr) mr_low++;
         if (cyc == pre_cyc) pre_chain = m_chain;
         if (m_cp == lvl) run++;
         else begin
            if (lvl) begin
               if (run < hmin) hmin = run;
               if (run > hmax) hmax = run;
            end else if (!first) begin
               if (run < lmin) lmin = run;
               if (run > lmax) lmax = run;
            end
            first = 0; lvl = m_cp; run = 1;
         end
         if (m_done) done_cyc = cyc;
      end
      edges = m_ecnt - base;
   endtask

   typedef struct {
      int          sel;
      logic [31:0] d;
      int          poke;
      int          exp_done;
      int          exp_edges;
      int          half;
      int          pre_cyc;
      logic [31:0] exp_pre;
   } vec_t;

   vec_t vt[7];

   initial begin
      int dc, ed, vi, ml, hmin, hmax, lmin, lmax, n, base;
      int cyc, d1, d2, idle;
      logic [31:0] pc;

      vt[0] = '{0, 32'h0000_00A5, 0, LA, 8,  1, 0, 32'h0};
      vt[1] = '{1, 32'h1234_5678, 0, LB, 32, 4, 0, 32'h0};
      vt[2] = '{0, 32'h0000_000F, 5, LA, 8,  1, 0, 32'h0};
      vt[3] = '{0, 32'h0000_0000, 0, LA, 8,  1, 0, 32'h0};
      vt[4] = '{1, 32'hFFFF_0000, 0, LB, 32, 4, 0, 32'h0};
      vt[5] = '{2, 32'h0000_00FF, 0, LC, 8,  2, 0, 32'h0};
      vt[6] = '{2, 32'h0000_005A, 0, LC, 8,  2, 1 + CLR * 4, (CLR != 0) ? 32'h0 : 32'hFF};

      // Reset values, then first edge after release.
      repeat (3) @(negedge CP);
      chk("rst_a", {26'h0, a_ready, a_busy, a_done, a_ds, a_cp, a_mr}, 32'h0);
      chk("rst_b", {26'h0, b_ready, b_busy, b_done, b_ds, b_cp, b_mr}, 32'h0);
      MR_n = 1'b1;
      @(negedge CP);
      chk("rel_a", {26'h0, a_ready, a_busy, a_done, a_ds, a_cp, a_mr}, 32'h21);
      chk("rel_c", {26'h0, c_ready, c_busy, c_done, c_ds, c_cp, c_mr}, 32'h21);

      for (int i = 0; i < 7; i++) begin
         run_frame(vt[i].sel, vt[i].d, vt[i].poke, vt[i].pre_cyc,
                   dc, ed, vi, ml, hmin, hmax, lmin, lmax, pc);
         chk($sformatf("v%0d_done_cyc", i), dc, vt[i].exp_done);
         chk($sformatf("v%0d_edges", i), ed, vt[i].exp_edges);
         chk($sformatf("v%0d_chain", i), m_chain, vt[i].d);
         chk($sformatf("v%0d_busy", i), vi, 0);
         chk($sformatf("v%0d_mr_low", i), ml, CLR * 2 * vt[i].half);
         chk($sformatf("v%0d_hi_run", i), {hmin[15:0], hmax[15:0]},
             {vt[i].half[15:0], vt[i].half[15:0]});
         chk($sformatf("v%0d_lo_run", i), {lmin[15:0], lmax[15:0]},
             {vt[i].half[15:0], vt[i].half[15:0]});
         if (vt[i].pre_cyc > 0) chk($sformatf("v%0d_pre_chain", i), pc, vt[i].exp_pre);
         @(negedge CP);
         chk($sformatf("v%0d_after", i), {30'h0, m_ready, m_done}, 32'h2);
      end

      // Reset pulse in the middle of edge 5.
      wait_ready(0);
      base = m_ecnt;
      set_in(0, 1'b1, 32'hF0);
      n = 0;
      @(negedge CP);
      set_in(0, 1'b0, 32'hF0);
      while (!((m_ecnt - base) == 5 && m_cp) && n < 200) begin @(negedge CP); n++; end
      chk("midrst_reached", (m_ecnt - base), 5);
      MR_n = 1'b0;
      #1;
      chk("midrst_outs", {26'h0, a_ready, a_busy, a_done, a_ds, a_cp, a_mr}, 32'h0);
      @(negedge CP);
      MR_n = 1'b1;
      @(negedge CP);
      chk("midrst_rel", {26'h0, a_ready, a_busy, a_done, a_ds, a_cp, a_mr}, 32'h21);
      run_frame(0, 32'h3C, 0, 0, dc, ed, vi, ml, hmin, hmax, lmin, lmax, pc);
      chk("midrst_done_cyc", dc, LA);
      chk("midrst_edges", ed, 8);
      chk("midrst_chain", m_chain, 32'h3C);

      // Start held high: back-to-back frames with a single idle cycle.
      wait_ready(0);
      set_in(0, 1'b1, 32'h81);
      cyc = 0; d1 = -1; d2 = -1; idle = 0;
      while (cyc < 2 * LA + 1) begin
         @(negedge CP);
         cyc++;
         if (m_done) begin
            if (d1 < 0) d1 = cyc;
            else if (d2 < 0) d2 = cyc;
         end
         if (m_ready) idle++;
      end
      set_in(0, 1'b0, 32'h0);
      chk("b2b_done1", d1, LA);
      chk("b2b_done2", d2, 2 * LA + 1);
      chk("b2b_idle", idle, 1);
      chk("b2b_chain", m_chain, 32'h81);
      @(negedge CP);
      @(negedge CP);
      chk("b2b_stop", {30'h0, m_ready, m_busy}, 32'h2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
